// File: rtl/dual_clk_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
package dual_clk_fifo_pkg;
    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;

    typedef logic [ASIZE_DEF:0]   ptr_t;
    typedef logic [DSIZE_DEF-1:0] word_t;
endpackage

// File: rtl/dual_clk_fifo_mem.sv
// 2**ASIZE x DSIZE storage: synchronous write port, asynchronous read port, no reset.
module dual_clk_fifo_mem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             wclk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);
    localparam int DEPTH = 1 << ASIZE;

    logic [DEPTH-1:0][DSIZE-1:0] mem;

    always_ff @(posedge wclk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dual_clk_fifo.sv
// First-word fall-through FIFO, read and write on one clock (wclk/wrst_n).
// Optional occupancy output wlevel under macro DUAL_CLK_FIFO_LEVEL_EN.
module dual_clk_fifo
    import dual_clk_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty
`ifdef DUAL_CLK_FIFO_LEVEL_EN
    ,
    output logic [ASIZE:0]   wlevel
`endif
);
    logic [1:0]     rst_sync;
    logic           rst_n;
    logic [ASIZE:0] wptr, rptr;
    logic           wr_en, rd_en;

    // Assertion passes straight through; release is retimed by two flops.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign wr_en = winc & ~wfull;
    assign rd_en = rinc & ~rempty;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    // Flags come only from registered pointers, never from winc/rinc.
    assign rempty = (wptr == rptr);
    assign wfull  = (wptr[ASIZE] != rptr[ASIZE]) &&
                    (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);

`ifdef DUAL_CLK_FIFO_LEVEL_EN
    assign wlevel = wptr - rptr;
`endif

    dual_clk_fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
        .wclk  (wclk),
        .we    (wr_en),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_dual_clk_fifo.sv
// Directed bench for dual_clk_fifo with a queue reference model.
module tb_dual_clk_fifo;
    import dual_clk_fifo_pkg::*;

    logic  wclk = 1'b0;
    logic  wrst_n;
    word_t wdata;
    logic  winc, rinc;
    word_t rdata;
    logic  wfull, rempty;
`ifdef DUAL_CLK_FIFO_LEVEL_EN
    logic [ASIZE_DEF:0] wlevel;
`endif

    int errors = 0;
    int checks = 0;
    word_t q[$];

    dual_clk_fifo #(.DSIZE(DSIZE_DEF), .ASIZE(ASIZE_DEF)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .wdata  (wdata),
        .winc   (winc),
        .rinc   (rinc),
        .rdata  (rdata),
        .wfull  (wfull),
        .rempty (rempty)
`ifdef DUAL_CLK_FIFO_LEVEL_EN
        ,
        .wlevel (wlevel)
`endif
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge wclk);
        @(negedge wclk);
    endtask

    task automatic push(input word_t d);
        winc = 1'b1; wdata = d;
        tick();
        winc = 1'b0;
        if (q.size() < 16) q.push_back(d);
    endtask

    task automatic both(input word_t d);
        int n;
        n = q.size();
        winc = 1'b1; rinc = 1'b1; wdata = d;
        tick();
        winc = 1'b0; rinc = 1'b0;
        if (n != 0)  void'(q.pop_front());
        if (n != 16) q.push_back(d);
    endtask

    // Pops until empty (bounded), checks every head word and the final count.
    task automatic drain(input string tag, input int exp_n);
        int n;
        n = 0;
        while (!rempty && n < 20) begin
            if (q.size() != 0) chk({tag, "_data"}, 32'(rdata), 32'(q[0]));
            rinc = 1'b1;
            tick();
            rinc = 1'b0;
            if (q.size() != 0) void'(q.pop_front());
            n++;
        end
        chk({tag, "_count"}, 32'(n), 32'(exp_n));
        chk({tag, "_empty"}, 32'(rempty), 32'd1);
    endtask

    initial begin
        word_t r;
        winc = 1'b0; rinc = 1'b0; wdata = '0;

        // Reset at time zero: flags valid before any clock edge.
        wrst_n = 1'b0;
        #1;
        chk("rst_empty", 32'(rempty), 32'd1);
        chk("rst_full",  32'(wfull),  32'd0);
`ifdef DUAL_CLK_FIFO_LEVEL_EN
        chk("rst_level", 32'(wlevel), 32'd0);
`endif
        @(negedge wclk);
        wrst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_empty", 32'(rempty), 32'd1);

        // Single word with fall-through.
        push(8'h5A);
        chk("single_empty", 32'(rempty), 32'd0);
        chk("single_data",  32'(rdata),  32'h5A);
        rinc = 1'b1; tick(); rinc = 1'b0; void'(q.pop_front());
        chk("single_pop_empty", 32'(rempty), 32'd1);

        // Fill to 16, overflow write ignored, drain in order.
        for (int i = 0; i < 15; i++) push(word_t'(i));
        chk("fill15_full", 32'(wfull), 32'd0);
        push(8'h0F);
        chk("fill16_full", 32'(wfull), 32'd1);
`ifdef DUAL_CLK_FIFO_LEVEL_EN
        chk("fill16_level", 32'(wlevel), 32'd16);
`endif
        push(8'hFF);
        chk("ovf_full", 32'(wfull), 32'd1);
        chk("ovf_head", 32'(rdata), 32'h00);
        drain("fill_drain", 16);

        // Underflow read ignored.
        rinc = 1'b1; tick(); rinc = 1'b0;
        chk("udf_empty", 32'(rempty), 32'd1);
        push(8'hC3);
        chk("udf_data", 32'(rdata), 32'hC3);
        drain("udf_drain", 1);

        // Alternating write/read, pointers wrap several times.
        for (int i = 0; i < 100; i++) begin
            r = word_t'($urandom_range(0, 255));
            push(r);
            chk("wrap_data", 32'(rdata), 32'(r));
            chk("wrap_full", 32'(wfull), 32'd0);
            rinc = 1'b1; tick(); rinc = 1'b0; void'(q.pop_front());
            chk("wrap_empty", 32'(rempty), 32'd1);
        end

        // Simultaneous at occupancy 5.
        for (int i = 0; i < 5; i++) push(word_t'(8'h10 + i));
        both(8'hA5);
`ifdef DUAL_CLK_FIFO_LEVEL_EN
        chk("sim5_level", 32'(wlevel), 32'd5);
`endif
        chk("sim5_head", 32'(rdata), 32'h11);
        drain("sim5_drain", 5);

        // Simultaneous when full: only the read.
        for (int i = 0; i < 16; i++) push(word_t'(8'h40 + i));
        chk("simf_pre_full", 32'(wfull), 32'd1);
        both(8'hEE);
        chk("simf_full", 32'(wfull), 32'd0);
`ifdef DUAL_CLK_FIFO_LEVEL_EN
        chk("simf_level", 32'(wlevel), 32'd15);
`endif
        chk("simf_head", 32'(rdata), 32'h41);
        drain("simf_drain", 15);

        // Simultaneous when empty: only the write.
        both(8'h77);
        chk("sime_empty", 32'(rempty), 32'd0);
        chk("sime_data",  32'(rdata),  32'h77);
`ifdef DUAL_CLK_FIFO_LEVEL_EN
        chk("sime_level", 32'(wlevel), 32'd1);
`endif
        drain("sime_drain", 1);

        // Reset mid-operation with 7 words stored.
        for (int i = 0; i < 7; i++) push(word_t'(8'h80 + i));
        chk("mid_pre_empty", 32'(rempty), 32'd0);
        wrst_n = 1'b0;
        #1;
        chk("mid_empty", 32'(rempty), 32'd1);
        chk("mid_full",  32'(wfull),  32'd0);
`ifdef DUAL_CLK_FIFO_LEVEL_EN
        chk("mid_level", 32'(wlevel), 32'd0);
`endif
        q.delete();
        @(negedge wclk);
        wrst_n = 1'b1;
        repeat (3) tick();
        chk("mid_post_empty", 32'(rempty), 32'd1);
        push(8'h3C);
        chk("mid_post_data", 32'(rdata), 32'h3C);
        drain("mid_post_drain", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
